rom_access_seq: RTL and testbench

ROM_ACCESS_SEQ -- requirements
Module: rom_access_seq

---
 rtl/rom_access_seq_if.sv | 40 ++++
 rtl/rom_access_seq.sv | 185 ++++++++++++++++++
 tb/tb_rom_access_seq.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_access_seq_if.sv
// Bus bundle for rom_access_seq: SNES request side, MCU request side and SRAM pins.
// The slave modport is the sequencer's view; master is the view of whoever drives it.
interface rom_access_seq_if;
   logic        SNES_RD_STROBE;
   logic        SNES_WR_STROBE;
   logic [23:0] SNES_MAPPED_ADDR;
   logic        SNES_ROM_HIT;
   logic        SNES_IS_WRITABLE;
   logic [7:0]  SNES_DATA_IN;
   logic [7:0]  SNES_DATA_OUT;
   logic        MCU_RRQ;
   logic        MCU_WRQ;
   logic [23:0] MCU_ADDR;
   logic [7:0]  MCU_WRDATA;
   logic [7:0]  MCU_RDDATA;
   logic        MCU_RDY;
   logic [23:0] RAM_ADDR;
   logic        RAM_CE_N;
   logic        RAM_OE_N;
   logic        RAM_WE_N;
   logic [7:0]  RAM_DQ_OUT;
   logic        RAM_DQ_OE;
   logic [7:0]  RAM_DQ_IN;

   modport slave (
      input  SNES_RD_STROBE, SNES_WR_STROBE, SNES_MAPPED_ADDR, SNES_ROM_HIT,
             SNES_IS_WRITABLE, SNES_DATA_IN, MCU_RRQ, MCU_WRQ, MCU_ADDR,
             MCU_WRDATA, RAM_DQ_IN,
      output SNES_DATA_OUT, MCU_RDDATA, MCU_RDY, RAM_ADDR, RAM_CE_N, RAM_OE_N,
             RAM_WE_N, RAM_DQ_OUT, RAM_DQ_OE
   );

   modport master (
      output SNES_RD_STROBE, SNES_WR_STROBE, SNES_MAPPED_ADDR, SNES_ROM_HIT,
             SNES_IS_WRITABLE, SNES_DATA_IN, MCU_RRQ, MCU_WRQ, MCU_ADDR,
             MCU_WRDATA, RAM_DQ_IN,
      input  SNES_DATA_OUT, MCU_RDDATA, MCU_RDY, RAM_ADDR, RAM_CE_N, RAM_OE_N,
             RAM_WE_N, RAM_DQ_OUT, RAM_DQ_OE
   );
endinterface

// File: rtl/rom_access_seq.sv
// Arbitrates SNES and MCU requests onto a single async SRAM, producing fixed-length
// read and write cycles with all pin controls registered.
module rom_access_seq #(
   parameter int RD_CYCLES = 6,
   parameter int WR_CYCLES = 5
) (
   input  logic CLK,
   input  logic RST_N,
   rom_access_seq_if.slave bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);
   localparam logic [3:0] WR_LOAD = 4'(WR_CYCLES - 1);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        owner_mcu_q, owner_mcu_d;

   logic        snes_pend_q, snes_pend_d;
   logic        snes_wr_q, snes_wr_d;
   logic [23:0] snes_addr_q, snes_addr_d;
   logic [7:0]  snes_data_q, snes_data_d;

   logic        mcu_pend_q, mcu_pend_d;
   logic        mcu_wr_q, mcu_wr_d;
   logic [23:0] mcu_addr_q, mcu_addr_d;
   logic [7:0]  mcu_data_q, mcu_data_d;

   logic [23:0] ram_addr_q, ram_addr_d;
   logic [7:0]  ram_dq_out_q, ram_dq_out_d;
   logic        ram_ce_n_q, ram_ce_n_d;
   logic        ram_oe_n_q, ram_oe_n_d;
   logic        ram_we_n_q, ram_we_n_d;
   logic        ram_dq_oe_q, ram_dq_oe_d;
   logic [7:0]  snes_rdata_q, snes_rdata_d;
   logic [7:0]  mcu_rdata_q, mcu_rdata_d;
   logic        mcu_rdy_q, mcu_rdy_d;

   logic        start_snes, start_mcu, mcu_active;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      owner_mcu_d  = owner_mcu_q;
      snes_pend_d  = snes_pend_q;
      snes_wr_d    = snes_wr_q;
      snes_addr_d  = snes_addr_q;
      snes_data_d  = snes_data_q;
      mcu_pend_d   = mcu_pend_q;
      mcu_wr_d     = mcu_wr_q;
      mcu_addr_d   = mcu_addr_q;
      mcu_data_d   = mcu_data_q;
      ram_addr_d   = ram_addr_q;
      ram_dq_out_d = ram_dq_out_q;
      snes_rdata_d = snes_rdata_q;
      mcu_rdata_d  = mcu_rdata_q;
      start_snes   = 1'b0;
      start_mcu    = 1'b0;

      case (state_q)
         // DONE arbitrates like IDLE so a waiting request starts right after DONE.
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (snes_pend_q) begin
               start_snes   = 1'b1;
               owner_mcu_d  = 1'b0;
               state_d      = snes_wr_q ? ST_WR : ST_RD;
               cnt_d        = snes_wr_q ? WR_LOAD : RD_LOAD;
               ram_addr_d   = snes_addr_q;
               ram_dq_out_d = snes_wr_q ? snes_data_q : ram_dq_out_q;
            end else if (mcu_pend_q) begin
               start_mcu    = 1'b1;
               owner_mcu_d  = 1'b1;
               state_d      = mcu_wr_q ? ST_WR : ST_RD;
               cnt_d        = mcu_wr_q ? WR_LOAD : RD_LOAD;
               ram_addr_d   = mcu_addr_q;
               ram_dq_out_d = mcu_wr_q ? mcu_data_q : ram_dq_out_q;
            end
         end
         default: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_DONE;
               // Read data is taken from the pins on the last RD cycle.
               if (state_q == ST_RD) begin
                  if (owner_mcu_q) mcu_rdata_d  = bus.RAM_DQ_IN;
                  else             snes_rdata_d = bus.RAM_DQ_IN;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
      endcase

      if (start_snes) snes_pend_d = 1'b0;
      if (start_mcu)  mcu_pend_d  = 1'b0;

      if (bus.SNES_RD_STROBE && bus.SNES_ROM_HIT) begin
         snes_pend_d = 1'b1;
         snes_wr_d   = 1'b0;
         snes_addr_d = bus.SNES_MAPPED_ADDR;
      end else if (bus.SNES_WR_STROBE && bus.SNES_IS_WRITABLE) begin
         snes_pend_d = 1'b1;
         snes_wr_d   = 1'b1;
         snes_addr_d = bus.SNES_MAPPED_ADDR;
         snes_data_d = bus.SNES_DATA_IN;
      end

      mcu_active = owner_mcu_q && (state_q != ST_IDLE);
      if (!mcu_pend_q && !mcu_active && (bus.MCU_RRQ || bus.MCU_WRQ)) begin
         mcu_pend_d = 1'b1;
         mcu_wr_d   = !bus.MCU_RRQ;
         mcu_addr_d = bus.MCU_ADDR;
         mcu_data_d = bus.MCU_WRDATA;
      end

      // Pin controls follow the next state, so OE and DQ_OE are exclusive by construction.
      ram_ce_n_d  = !((state_d == ST_RD) || (state_d == ST_WR));
      ram_oe_n_d  = (state_d != ST_RD);
      ram_dq_oe_d = (state_d == ST_WR);
      ram_we_n_d  = !((state_d == ST_WR) && (cnt_d != 4'd0));
      mcu_rdy_d   = (state_d == ST_DONE) && owner_mcu_d;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         owner_mcu_q  <= 1'b0;
         snes_pend_q  <= 1'b0;
         snes_wr_q    <= 1'b0;
         snes_addr_q  <= 24'd0;
         snes_data_q  <= 8'd0;
         mcu_pend_q   <= 1'b0;
         mcu_wr_q     <= 1'b0;
         mcu_addr_q   <= 24'd0;
         mcu_data_q   <= 8'd0;
         ram_addr_q   <= 24'd0;
         ram_dq_out_q <= 8'd0;
         ram_ce_n_q   <= 1'b1;
         ram_oe_n_q   <= 1'b1;
         ram_we_n_q   <= 1'b1;
         ram_dq_oe_q  <= 1'b0;
         snes_rdata_q <= 8'd0;
         mcu_rdata_q  <= 8'd0;
         mcu_rdy_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         owner_mcu_q  <= owner_mcu_d;
         snes_pend_q  <= snes_pend_d;
         snes_wr_q    <= snes_wr_d;
         snes_addr_q  <= snes_addr_d;
         snes_data_q  <= snes_data_d;
         mcu_pend_q   <= mcu_pend_d;
         mcu_wr_q     <= mcu_wr_d;
         mcu_addr_q   <= mcu_addr_d;
         mcu_data_q   <= mcu_data_d;
         ram_addr_q   <= ram_addr_d;
         ram_dq_out_q <= ram_dq_out_d;
         ram_ce_n_q   <= ram_ce_n_d;
         ram_oe_n_q   <= ram_oe_n_d;
         ram_we_n_q   <= ram_we_n_d;
         ram_dq_oe_q  <= ram_dq_oe_d;
         snes_rdata_q <= snes_rdata_d;
         mcu_rdata_q  <= mcu_rdata_d;
         mcu_rdy_q    <= mcu_rdy_d;
      end
   end

   assign bus.RAM_ADDR      = ram_addr_q;
   assign bus.RAM_DQ_OUT    = ram_dq_out_q;
   assign bus.RAM_CE_N      = ram_ce_n_q;
   assign bus.RAM_OE_N      = ram_oe_n_q;
   assign bus.RAM_WE_N      = ram_we_n_q;
   assign bus.RAM_DQ_OE     = ram_dq_oe_q;
   assign bus.SNES_DATA_OUT = snes_rdata_q;
   assign bus.MCU_RDDATA    = mcu_rdata_q;
   assign bus.MCU_RDY       = mcu_rdy_q;

endmodule

// File: tb/tb_rom_access_seq.sv
// Scoreboard bench for rom_access_seq: each request pushes its expected SRAM access,
// a bus monitor pops and checks it when the access reaches its DONE cycle.
module tb_rom_access_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   rom_access_seq_if bus ();

   rom_access_seq #(.RD_CYCLES(6), .WR_CYCLES(5)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // SRAM model: read data is a fixed function of the address (0x123456 -> 0xA5).
   assign bus.RAM_DQ_IN = bus.RAM_ADDR[7:0] ^ 8'hF3;

   typedef struct {
      bit          wr;
      bit          mcu;
      logic [23:0] addr;
      logic [7:0]  data;
      int          gap;
   } exp_t;

   exp_t sb[$];
   int n_vec = 0;
   int n_err = 0;
   int rdy_seen = 0;
   int rdy_exp = 0;
   int acc_cnt = 0;
   int overlap = 0;
   int addr_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic push(input bit wr, input bit mcu, input logic [23:0] a,
                       input logic [7:0] d, input int gap);
      exp_t e;
      e.wr   = wr;
      e.mcu  = mcu;
      e.addr = a;
      e.data = wr ? d : (a[7:0] ^ 8'hF3);
      e.gap  = gap;
      sb.push_back(e);
      if (mcu) rdy_exp++;
   endtask

   // Bus monitor: measures each CE_N-low burst and checks it against the scoreboard.
   initial begin
      bit in_acc;
      int ce_len, oe_len, dq_len, we_len, idle_len, gap;
      logic [23:0] a0;
      logic [7:0]  d0;
      exp_t e;
      in_acc = 0; idle_len = 0; gap = 0;
      ce_len = 0; oe_len = 0; dq_len = 0; we_len = 0;
      a0 = '0; d0 = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_acc   = 0;
            idle_len = 0;
         end else begin
            if (bus.MCU_RDY) rdy_seen++;
            if (!bus.RAM_CE_N) begin
               if (!in_acc) begin
                  in_acc = 1; gap = idle_len; acc_cnt++;
                  ce_len = 0; oe_len = 0; dq_len = 0; we_len = 0;
                  a0 = bus.RAM_ADDR; d0 = bus.RAM_DQ_OUT;
               end
               ce_len++;
               if (!bus.RAM_OE_N) oe_len++;
               if (bus.RAM_DQ_OE) dq_len++;
               if (!bus.RAM_WE_N) we_len++;
               if (!bus.RAM_OE_N && bus.RAM_DQ_OE) overlap++;
               if (bus.RAM_ADDR !== a0) addr_bad++;
            end else if (in_acc) begin
               in_acc = 0;
               idle_len = 0;
               if (sb.size() == 0) begin
                  check_val("unexpected_access", 32'(a0), 32'hFFFF_FFFF);
               end else begin
                  e = sb.pop_front();
                  $display("[%0t] access %s %s addr=0x%06h ce=%0d oe=%0d dqoe=%0d we=%0d",
                           $time, e.mcu ? "MCU" : "SNES", e.wr ? "WR" : "RD", a0,
                           ce_len, oe_len, dq_len, we_len);
                  check_val("acc_addr", 32'(a0), 32'(e.addr));
                  check_val("acc_kind_wr", 32'(dq_len > 0), 32'(e.wr));
                  check_val("done_ctrl", {29'd0, bus.RAM_OE_N, bus.RAM_WE_N, bus.RAM_DQ_OE}, 32'b110);
                  check_val("done_rdy", 32'(bus.MCU_RDY), 32'(e.mcu));
                  if (e.gap >= 0) check_val("start_gap", 32'(gap), 32'(e.gap));
                  if (e.wr) begin
                     check_val("wr_ce_len", 32'(ce_len), 32'd5);
                     check_val("wr_dqoe_len", 32'(dq_len), 32'd5);
                     check_val("wr_we_len", 32'(we_len), 32'd4);
                     check_val("wr_oe_len", 32'(oe_len), 32'd0);
                     check_val("wr_data", 32'(d0), 32'(e.data));
                  end else begin
                     check_val("rd_ce_len", 32'(ce_len), 32'd6);
                     check_val("rd_oe_len", 32'(oe_len), 32'd6);
                     check_val("rd_dqoe_len", 32'(dq_len), 32'd0);
                     check_val("rd_we_len", 32'(we_len), 32'd0);
                     if (e.mcu) check_val("mcu_rddata", 32'(bus.MCU_RDDATA), 32'(e.data));
                     else       check_val("snes_data_out", 32'(bus.SNES_DATA_OUT), 32'(e.data));
                  end
               end
            end else begin
               idle_len++;
            end
         end
      end
   end

   task automatic snes_pulse(input bit rd, input bit wr, input bit hit, input bit wbl,
                             input logic [23:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.SNES_RD_STROBE = rd; bus.SNES_WR_STROBE = wr;
      bus.SNES_ROM_HIT = hit; bus.SNES_IS_WRITABLE = wbl;
      bus.SNES_MAPPED_ADDR = a; bus.SNES_DATA_IN = d;
      @(negedge clk);
      bus.SNES_RD_STROBE = 0; bus.SNES_WR_STROBE = 0;
   endtask

   task automatic mcu_pulse(input bit rrq, input bit wrq, input logic [23:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.MCU_RRQ = rrq; bus.MCU_WRQ = wrq; bus.MCU_ADDR = a; bus.MCU_WRDATA = d;
      @(negedge clk);
      bus.MCU_RRQ = 0; bus.MCU_WRQ = 0;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && bus.RAM_CE_N) break;
      end
      check_val(tag, 32'(sb.size()), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_ce_low(input string tag);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!bus.RAM_CE_N) break;
      end
      check_val(tag, 32'(bus.RAM_CE_N), 32'd0);
   endtask

   initial begin
      int base;
      bus.SNES_RD_STROBE = 0; bus.SNES_WR_STROBE = 0; bus.SNES_MAPPED_ADDR = '0;
      bus.SNES_ROM_HIT = 0; bus.SNES_IS_WRITABLE = 0; bus.SNES_DATA_IN = '0;
      bus.MCU_RRQ = 0; bus.MCU_WRQ = 0; bus.MCU_ADDR = '0; bus.MCU_WRDATA = '0;
      repeat (3) @(negedge clk);

      check_val("rst_ce_n", 32'(bus.RAM_CE_N), 32'd1);
      check_val("rst_oe_n", 32'(bus.RAM_OE_N), 32'd1);
      check_val("rst_we_n", 32'(bus.RAM_WE_N), 32'd1);
      check_val("rst_dq_oe", 32'(bus.RAM_DQ_OE), 32'd0);
      check_val("rst_addr", 32'(bus.RAM_ADDR), 32'd0);
      check_val("rst_dq_out", 32'(bus.RAM_DQ_OUT), 32'd0);
      check_val("rst_mcu_rdy", 32'(bus.MCU_RDY), 32'd0);
      rst_n = 1;
      @(negedge clk);

      // Plain SNES read.
      push(0, 0, 24'h123456, 8'h00, -1);
      snes_pulse(1, 0, 1, 0, 24'h123456, 8'h00);
      wait_idle("snes_read_done");
      check_val("snes_data_hold", 32'(bus.SNES_DATA_OUT), 32'hA5);

      // Discarded strobes: unwritable write and ROM miss read.
      base = acc_cnt;
      snes_pulse(0, 1, 0, 0, 24'h7E0000, 8'h11);
      snes_pulse(1, 0, 0, 0, 24'h7E0001, 8'h00);
      repeat (12) @(negedge clk);
      check_val("discard_no_access", 32'(acc_cnt), 32'(base));
      check_val("discard_ce_n", 32'(bus.RAM_CE_N), 32'd1);
      check_val("discard_addr_hold", 32'(bus.RAM_ADDR), 32'h123456);

      // Writable SNES write.
      push(1, 0, 24'h400100, 8'h77, -1);
      snes_pulse(0, 1, 0, 1, 24'h400100, 8'h77);
      wait_idle("snes_write_done");

      // Same-cycle SNES read and MCU write: SNES first.
      base = rdy_seen;
      push(0, 0, 24'h0A0B0C, 8'h00, -1);
      push(1, 1, 24'hE00010, 8'h3C, 0);
      @(negedge clk);
      bus.SNES_RD_STROBE = 1; bus.SNES_ROM_HIT = 1; bus.SNES_MAPPED_ADDR = 24'h0A0B0C;
      bus.MCU_WRQ = 1; bus.MCU_ADDR = 24'hE00010; bus.MCU_WRDATA = 8'h3C;
      @(negedge clk);
      bus.SNES_RD_STROBE = 0; bus.MCU_WRQ = 0;
      wait_idle("priority_done");
      check_val("priority_rdy_cnt", 32'(rdy_seen - base), 32'd1);

      // SNES strobe during an MCU read: no preemption, starts right after DONE.
      push(0, 1, 24'h00ABCD, 8'h00, -1);
      mcu_pulse(1, 0, 24'h00ABCD, 8'h00);
      wait_ce_low("preempt_mcu_start");
      @(negedge clk);
      push(0, 0, 24'h123400, 8'h00, 0);
      snes_pulse(1, 0, 1, 0, 24'h123400, 8'h00);
      wait_idle("preempt_done");

      // Both MCU requests in one cycle: read only.
      base = rdy_seen;
      push(0, 1, 24'h00C0DE, 8'h00, -1);
      mcu_pulse(1, 1, 24'h00C0DE, 8'h5A);
      wait_idle("dual_mcu_done");
      check_val("dual_mcu_rdy_cnt", 32'(rdy_seen - base), 32'd1);

      // During an MCU access: MCU request ignored, later SNES strobe overwrites earlier one.
      base = rdy_seen;
      push(0, 1, 24'h000777, 8'h00, -1);
      mcu_pulse(1, 0, 24'h000777, 8'h00);
      wait_ce_low("ovw_mcu_start");
      mcu_pulse(0, 1, 24'h000888, 8'h66);
      snes_pulse(1, 0, 1, 0, 24'h111111, 8'h00);
      push(0, 0, 24'h222222, 8'h00, -1);
      snes_pulse(1, 0, 1, 0, 24'h222222, 8'h00);
      wait_idle("overwrite_done");
      check_val("ovw_rdy_cnt", 32'(rdy_seen - base), 32'd1);

      // Reset in the second WR cycle of an MCU write.
      base = rdy_seen;
      mcu_pulse(0, 1, 24'h00F0F0, 8'h99);
      for (int i = 0; i < 50; i++) begin
         if (bus.RAM_DQ_OE) break;
         @(negedge clk);
      end
      check_val("rstw_dq_oe_seen", 32'(bus.RAM_DQ_OE), 32'd1);
      @(negedge clk);
      check_val("rstw_we_low_before", 32'(bus.RAM_WE_N), 32'd0);
      rst_n = 0;
      #1;
      check_val("rstw_we_n", 32'(bus.RAM_WE_N), 32'd1);
      check_val("rstw_dq_oe", 32'(bus.RAM_DQ_OE), 32'd0);
      check_val("rstw_ce_n", 32'(bus.RAM_CE_N), 32'd1);
      check_val("rstw_rdy", 32'(bus.MCU_RDY), 32'd0);
      check_val("rstw_snes_data", 32'(bus.SNES_DATA_OUT), 32'd0);
      check_val("rstw_mcu_data", 32'(bus.MCU_RDDATA), 32'd0);
      check_val("rstw_addr", 32'(bus.RAM_ADDR), 32'd0);
      @(negedge clk);
      rst_n = 1;
      repeat (15) @(negedge clk);
      check_val("rstw_no_rdy", 32'(rdy_seen - base), 32'd0);
      check_val("rstw_idle_ce_n", 32'(bus.RAM_CE_N), 32'd1);

      check_val("sb_drained", 32'(sb.size()), 32'd0);
      check_val("oe_dqoe_overlap", 32'(overlap), 32'd0);
      check_val("addr_unstable", 32'(addr_bad), 32'd0);
      check_val("mcu_rdy_total", 32'(rdy_seen), 32'(rdy_exp));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
